// File: rtl/esp_fifo_ram.sv
// Simple dual-port RAM for the UART FIFO: one write port, one read port with a
// registered, enable-gated output. The output register has a synchronous reset
// so the FIFO's read data starts at zero; the storage array itself is never reset.
module esp_fifo_ram #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic                  re,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem_q [2**DEPTH_LOG2];
   logic [WIDTH-1:0] rdata_q;

   // Write port: storage only, no reset so the array maps onto RAM primitives.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read port: registered output, holds its value when no read is requested.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata_q <= '0;
      end else if (re) begin
         rdata_q <= mem_q[raddr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/esp_uart_fifo_gen.sv
// Parametrised synchronous FIFO for the UART RX/TX paths. Pointers carry one
// extra bit so all DEPTH slots are usable; occupancy is their modular difference.
// Status outputs are combinational from the pointers; overflow/underflow are sticky.
module esp_uart_fifo_gen #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_LEVEL   = 8,
   parameter int AE_LEVEL   = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    wrdata,
   input  logic                wr_en,
   output logic [WIDTH-1:0]    rddata,
   input  logic                rd_en,
   input  logic                flush,
   input  logic                err_clr,
   output logic [DEPTH_LOG2:0] count,
   output logic                empty,
   output logic                full,
   output logic                almost_full,
   output logic                almost_empty,
   output logic                overflow,
   output logic                underflow
);

   localparam int PW = DEPTH_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(2 ** DEPTH_LOG2);
   localparam logic [PW-1:0] AF_P    = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_P    = PW'(AE_LEVEL);

   logic [PW-1:0] wrptr_q, wrptr_d;
   logic [PW-1:0] rdptr_q, rdptr_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          do_push, do_pop, push_err, pop_err;

   // Occupancy and flow status, all derived from the pre-edge pointers.
   assign count        = wrptr_q - rdptr_q;
   assign empty        = (count == '0);
   assign full         = (count == DEPTH_P);
   assign almost_full  = (count >= AF_P);
   assign almost_empty = (count <= AE_P);

   // Flush wins over push/pop; push and pop are each judged on pre-edge state.
   assign do_push  = wr_en & ~full  & ~flush;
   assign do_pop   = rd_en & ~empty & ~flush;
   assign push_err = wr_en &  full  & ~flush;
   assign pop_err  = rd_en &  empty & ~flush;

   // Next-state for pointers and sticky flags; a new error beats err_clr.
   always_comb begin
      wrptr_d     = wrptr_q;
      rdptr_d     = rdptr_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         rdptr_d = wrptr_q;
      end else begin
         if (do_push) wrptr_d = wrptr_q + 1'b1;
         if (do_pop)  rdptr_d = rdptr_q + 1'b1;
      end
      if (err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (push_err) overflow_d  = 1'b1;
      if (pop_err)  underflow_d = 1'b1;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wrptr_q     <= '0;
         rdptr_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wrptr_q     <= wrptr_d;
         rdptr_q     <= rdptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Storage; writes are blocked while reset is held.
   esp_fifo_ram #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (do_push & rst),
      .waddr (wrptr_q[DEPTH_LOG2-1:0]),
      .wdata (wrdata),
      .re    (do_pop & rst),
      .raddr (rdptr_q[DEPTH_LOG2-1:0]),
      .rdata (rddata)
   );

endmodule

// File: tb/tb_esp_uart_fifo_gen.sv
// Self-checking bench for esp_uart_fifo_gen (WIDTH=8, DEPTH=16, AF=8, AE=1).
// A queue-based model tracks contents and flags; a negedge process compares every
// cycle, and the directed sequence also pins hand-computed literal values.
module tb_esp_uart_fifo_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] wrdata = '0;
   logic       wr_en = 1'b0, rd_en = 1'b0, flush = 1'b0, err_clr = 1'b0;
   logic [7:0] rddata;
   logic [4:0] count;
   logic       empty, full, almost_full, almost_empty, overflow, underflow;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model state
   logic [7:0] mq[$];
   logic [7:0] m_rd = '0;
   bit         m_ovf = 0, m_unf = 0;
   bit         chk_en = 0;

   esp_uart_fifo_gen #(
      .WIDTH(8), .DEPTH_LOG2(4), .AF_LEVEL(8), .AE_LEVEL(1)
   ) dut (
      .clk(clk), .rst(rst), .wrdata(wrdata), .wr_en(wr_en), .rddata(rddata),
      .rd_en(rd_en), .flush(flush), .err_clr(err_clr), .count(count),
      .empty(empty), .full(full), .almost_full(almost_full),
      .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
   );

   always #5 clk = ~clk;

   // model update at each rising edge from the inputs held stable since the last edge
   always @(posedge clk) begin
      bit was_full, was_empty, new_ovf, new_unf;
      if (!rst) begin
         mq.delete();
         m_rd  = '0;
         m_ovf = 0;
         m_unf = 0;
         chk_en = 1;
      end else begin
         was_full  = (mq.size() == 16);
         was_empty = (mq.size() == 0);
         new_ovf = 0;
         new_unf = 0;
         if (flush) begin
            mq.delete();
         end else begin
            new_ovf = wr_en && was_full;
            new_unf = rd_en && was_empty;
            if (rd_en && !was_empty) m_rd = mq.pop_front();
            if (wr_en && !was_full)  mq.push_back(wrdata);
         end
         if (err_clr) begin
            m_ovf = 0;
            m_unf = 0;
         end
         if (new_ovf) m_ovf = 1;
         if (new_unf) m_unf = 1;
      end
   end

   // compare every cycle once the model has seen a reset
   always @(negedge clk) begin
      int n;
      if (chk_en) begin
         n = mq.size();
         vectors++;
         if (count !== 5'(n)) begin miscompares++; $display("FAIL count: got %0d want %0d @%0t", count, n, $time); end
         if (empty !== (n == 0)) begin miscompares++; $display("FAIL empty: got %b want %b @%0t", empty, (n == 0), $time); end
         if (full !== (n == 16)) begin miscompares++; $display("FAIL full: got %b want %b @%0t", full, (n == 16), $time); end
         if (almost_full !== (n >= 8)) begin miscompares++; $display("FAIL almost_full: got %b want %b @%0t", almost_full, (n >= 8), $time); end
         if (almost_empty !== (n <= 1)) begin miscompares++; $display("FAIL almost_empty: got %b want %b @%0t", almost_empty, (n <= 1), $time); end
         if (overflow !== m_ovf) begin miscompares++; $display("FAIL overflow: got %b want %b @%0t", overflow, m_ovf, $time); end
         if (underflow !== m_unf) begin miscompares++; $display("FAIL underflow: got %b want %b @%0t", underflow, m_unf, $time); end
         if (rddata !== m_rd) begin miscompares++; $display("FAIL rddata: got %02h want %02h @%0t", rddata, m_rd, $time); end
      end
   end

   task automatic lit(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h @%0t", name, act, exp, $time);
      end
   endtask

   // apply one cycle of inputs; returns 1ns after the edge that consumed them
   task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f, input bit c);
      wr_en = w; wrdata = d; rd_en = r; flush = f; err_clr = c;
      @(posedge clk);
      #1;
      wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
   endtask

   task automatic check_reset_values(input string tag);
      lit({tag, "_count"}, int'(count), 0);
      lit({tag, "_empty"}, int'(empty), 1);
      lit({tag, "_ae"}, int'(almost_empty), 1);
      lit({tag, "_full"}, int'(full), 0);
      lit({tag, "_af"}, int'(almost_full), 0);
      lit({tag, "_ovf"}, int'(overflow), 0);
      lit({tag, "_unf"}, int'(underflow), 0);
      lit({tag, "_rddata"}, int'(rddata), 0);
   endtask

   initial begin
      int n;
      int p_wr, p_rd;
      // reset
      rst = 0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst = 1;
      cyc(0, 8'h00, 0, 0, 0);
      check_reset_values("idle");

      // fill 0x01..0x10
      for (int i = 1; i <= 16; i++) begin
         cyc(1, 8'(i), 0, 0, 0);
         lit("fill_af", int'(almost_full), (i >= 8) ? 1 : 0);
      end
      lit("fill_full", int'(full), 1);
      lit("fill_count", int'(count), 16);
      cyc(1, 8'hAA, 0, 0, 0);
      lit("ovf_count", int'(count), 16);
      lit("ovf_set", int'(overflow), 1);
      cyc(0, 8'h00, 0, 0, 1);
      lit("ovf_clr", int'(overflow), 0);

      // drain in order
      for (int i = 1; i <= 16; i++) begin
         cyc(0, 8'h00, 1, 0, 0);
         lit("drain_data", int'(rddata), i);
      end
      lit("drain_empty", int'(empty), 1);
      cyc(0, 8'h00, 1, 0, 0);
      lit("unf_set", int'(underflow), 1);
      lit("unf_hold", int'(rddata), 8'h10);
      cyc(0, 8'h00, 0, 0, 1);

      // wrap: interleaved traffic, drain, then full refill and drain
      for (int i = 0; i < 40; i++)
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 0, 0);
      n = 0;
      while (count != 0 && n < 20) begin
         cyc(0, 8'h00, 1, 0, 0);
         n++;
      end
      lit("wrap_drained", int'(count), 0);
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
      lit("wrap_full", int'(count), 16);
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00, 1, 0, 0);
         lit("wrap_data", int'(rddata), 8'h20 + i);
      end

      // simultaneous push/pop at count 5, 16 and 0
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0, 0);
      cyc(1, 8'h55, 1, 0, 0);
      lit("sim5_count", int'(count), 5);
      lit("sim5_data", int'(rddata), 8'h50);
      for (int i = 0; i < 11; i++) cyc(1, 8'(8'h56 + i), 0, 0, 0);
      lit("sim16_pre", int'(count), 16);
      cyc(1, 8'h61, 1, 0, 0);
      lit("sim16_count", int'(count), 15);
      lit("sim16_ovf", int'(overflow), 1);
      lit("sim16_data", int'(rddata), 8'h51);
      cyc(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0, 0);
      lit("sim0_pre_data", int'(rddata), 8'h60);
      cyc(1, 8'h62, 1, 0, 0);
      lit("sim0_count", int'(count), 1);
      lit("sim0_unf", int'(underflow), 1);
      lit("sim0_data", int'(rddata), 8'h60);
      cyc(0, 8'h00, 0, 0, 1);

      // flush at count 9 with a push pending
      for (int i = 0; i < 8; i++) cyc(1, 8'(8'h63 + i), 0, 0, 0);
      lit("flush_pre", int'(count), 9);
      cyc(1, 8'hEE, 0, 1, 0);
      lit("flush_count", int'(count), 0);
      lit("flush_empty", int'(empty), 1);
      lit("flush_rddata", int'(rddata), 8'h60);
      cyc(1, 8'h77, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      lit("post_flush_data", int'(rddata), 8'h77);

      // reset mid-stream at count 7
      for (int i = 0; i < 7; i++) cyc(1, 8'(8'h80 + i), 0, 0, 0);
      cyc(1, 8'h00, 1, 0, 0);
      lit("pre_rst_count", int'(count), 7);
      rst = 0;
      cyc(1, 8'h99, 1, 0, 0);
      rst = 1;
      check_reset_values("midrst");

      // randomized phase with shifting push/pop bias
      for (int seg = 0; seg < 12; seg++) begin
         p_wr = (seg % 3 == 0) ? 80 : (seg % 3 == 1) ? 20 : 50;
         p_rd = (seg % 3 == 0) ? 25 : (seg % 3 == 1) ? 80 : 50;
         for (int i = 0; i < 150; i++) begin
            wr_en   = ($urandom_range(0, 99) < p_wr);
            rd_en   = ($urandom_range(0, 99) < p_rd);
            wrdata  = 8'($urandom);
            flush   = ($urandom_range(0, 99) < 2);
            err_clr = ($urandom_range(0, 99) < 5);
            rst     = ($urandom_range(0, 999) >= 3);
            @(posedge clk);
            #1;
         end
      end
      rst = 1; wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
      @(posedge clk);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
